muxn_arb: RTL and testbench
===========================

# muxn_arb

Parametrised N-input, WIDTH-bit arbitrated multiplexer with valid/ready handshakes and a registered output stage. It is the sequential successor to the 2:1 combinational mux and is used wherever several datapath producers share one consumer, such as writeback sources or bus masters. Selection is round-robin or fixed-priority, chosen by parameter. The block provides one-cycle latency and full throughput.

## Interface
- WIDTH, 8: data width per channel, ≥1.
- N, 4: number of input channels, ≥1.
- RR, 1: arbitration mode. 1 = round-robin; 0 = fixed priority, where the lowest index wins.
- SW = (N>1) ? $clog2(N) : 1: local width of the select/index fields.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to clk upstream.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept, combinational, one-hot or zero.
- out_data  out  WIDTH  registered payload.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_sel  out  SW  index of the channel that supplied out_data.

## Operation
- State consists of the output register (out_data, out_valid, out_sel) and the round-robin pointer ptr[SW-1:0].
- The output register can load (`load_ok`) when `!out_valid || out_ready`.
- Grant selection:
  - RR=1: the first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - RR=0: the lowest i with in_valid[i]=1; ptr is unused and held at 0.
- in_ready[g] = load_ok && in_valid[g] for the granted g only. All other bits are 0. in_ready is 0 for every channel when no channel is valid.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - out_data <= the channel g slice; out_sel <= g; out_valid <= 1.
  - RR=1: ptr <= (g == N-1) ? 0 : g+1.
- If out_valid && out_ready and no input transfers, out_valid <= 0. out_data and out_sel hold their last values.
- Drain and load in the same cycle is legal: the new word replaces the old one, and out_valid stays 1.
- If out_valid && !out_ready (stall), out_data, out_sel, out_valid and ptr all hold. in_ready is all zero.
- Producers must keep in_data and in_valid stable until the transfer occurs. The block does not check this.
- N=1: the block degenerates to a one-entry pipeline register. out_sel is always 0.
- Reset (asynchronous, at any time, including mid-stall): out_valid=0, out_data=0, out_sel=0, ptr=0. A pending word is discarded.

## Timing
- Latency: an input transfer in cycle t gives out_valid=1 with that data from cycle t+1.
- Throughput: one word per cycle while out_ready=1 and at least one input is valid.
- The combinational path runs from in_valid and out_ready to in_ready. There is no path from input to output data within the same cycle.
- Fairness with RR=1: with k channels continuously valid and no stalls, each is granted exactly once in every k consecutive transfers.
- While stalled, ptr is frozen, so no channel loses its turn.

## Test plan
- Reset behaviour:
  - Assert reset mid-stall with out_valid=1 and out_data=8'hAA.
  - Required: out_valid=0, out_data=0 and out_sel=0 immediately.
  - Required after release, with all in_valid=0: out_valid stays 0 and in_ready=0.
- Round-robin, N=4, WIDTH=8, RR=1:
  - Stimulus: channels 0..3 hold 8'h10, 8'h21, 8'h32, 8'h43, all valid, out_ready=1.
  - Required: out_sel sequence 0,1,2,3,0,1 with matching data, one word per cycle from the second cycle.
- Pointer wrap/skip:
  - Stimulus: only channels 3 and 1 valid, after the last grant was 2.
  - Required: grant 3, then 1 (wrapping past 0), then 3.
- Backpressure:
  - Stimulus: out_valid=1 with 8'h55 and out_ready=0 for 3 cycles, while all inputs are valid.
  - Required: in_ready=0, and out_data=8'h55 with out_sel unchanged.
  - Required on out_ready=1: the next grant is the next channel in round-robin order.
- Fixed priority, RR=0:
  - Stimulus: channels 1 and 2 continuously valid.
  - Required: every grant goes to 1, and channel 2 never gets in_ready. When channel 1 drops, channel 2 is granted the next cycle.
- Simultaneous drain and load:
  - Stimulus: out_valid=1 with 8'hAA, out_ready=1, and channel 0 valid with 8'h0F in the same cycle.
  - Required: next cycle out_valid=1 and out_data=8'h0F, with no bubble.

Source files
------------

// File: rtl/muxn_arb.sv
// N-input arbitrated multiplexer with valid/ready handshakes and a registered output stage.
// Round-robin (RR=1) or lowest-index fixed priority (RR=0); one-cycle latency, full throughput.
module muxn_arb #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int RR    = 1,
   parameter int SW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SW-1:0]      out_sel
);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [SW-1:0]    r_out_sel;
   logic [SW-1:0]    r_ptr;

   logic             w_load_ok;
   logic             w_xfer;
   logic [SW-1:0]    w_ptr_eff;
   logic [2*N-1:0]   w_req2;
   logic             w_gnt_vld;
   int               w_gnt_ofs;
   int               w_gnt_sum;
   logic [SW-1:0]    w_gnt_idx;
   logic [WIDTH-1:0] w_gnt_data;
   logic [SW-1:0]    w_ptr_nxt;

   assign w_load_ok = !r_out_valid || out_ready;
   assign w_ptr_eff = (RR != 0) ? r_ptr : '0;
   assign w_xfer    = w_gnt_vld && w_load_ok;

   // Rotate requests so the search starts at the pointer; the lowest rotated offset wins.
   always_comb begin
      w_req2    = {in_valid, in_valid} >> w_ptr_eff;
      w_gnt_vld = 1'b0;
      w_gnt_ofs = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_req2[k]) begin
            w_gnt_vld = 1'b1;
            w_gnt_ofs = k;
         end else begin
            w_gnt_ofs = w_gnt_ofs;
         end
      end
      w_gnt_sum = int'(w_ptr_eff) + w_gnt_ofs;
      if (w_gnt_sum >= N) begin
         w_gnt_idx = SW'(w_gnt_sum - N);
      end else begin
         w_gnt_idx = SW'(w_gnt_sum);
      end
   end

   // Payload of the granted channel.
   always_comb begin
      w_gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (SW'(i) == w_gnt_idx) begin
            w_gnt_data = in_data[i*WIDTH +: WIDTH];
         end else begin
            w_gnt_data = w_gnt_data;
         end
      end
   end

   // Accept only the granted channel, and only when the output register can take a word.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = w_xfer && (SW'(i) == w_gnt_idx);
      end
   end

   // Pointer moves just past the winner; fixed priority keeps it at zero.
   always_comb begin
      if ((RR != 0) && (w_gnt_idx != SW'(N - 1))) begin
         w_ptr_nxt = w_gnt_idx + SW'(1);
      end else begin
         w_ptr_nxt = '0;
      end
   end

   // Output register and round-robin pointer; a stall freezes both.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_sel   <= '0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out_data  <= w_gnt_data;
         r_out_valid <= 1'b1;
         r_out_sel   <= w_gnt_idx;
         r_ptr       <= w_ptr_nxt;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb: a round-robin and a fixed-priority instance, N=4, WIDTH=8.
module tb_muxn_arb;

   logic        clk;
   logic        rst_n;

   logic [31:0] rr_in_data;
   logic [3:0]  rr_in_valid;
   logic [3:0]  rr_in_ready;
   logic [7:0]  rr_out_data;
   logic        rr_out_valid;
   logic        rr_out_ready;
   logic [1:0]  rr_out_sel;

   logic [31:0] fp_in_data;
   logic [3:0]  fp_in_valid;
   logic [3:0]  fp_in_ready;
   logic [7:0]  fp_out_data;
   logic        fp_out_valid;
   logic        fp_out_ready;
   logic [1:0]  fp_out_sel;

   int n_tests = 0;
   int n_fail  = 0;

   // expected words: {sel[7:0], data[7:0]}
   logic [15:0] rr_q[$];
   logic [15:0] fp_q[$];
   logic [15:0] rr_exp;
   logic [15:0] fp_exp;
   logic [3:0]  exp_rdy;
   logic [3:0]  wrap_rdy [3] = '{4'b1000, 4'b0010, 4'b1000};

   muxn_arb #(.WIDTH(8), .N(4), .RR(1)) u_rr (
      .clk(clk), .reset(rst_n),
      .in_data(rr_in_data), .in_valid(rr_in_valid), .in_ready(rr_in_ready),
      .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(rr_out_ready),
      .out_sel(rr_out_sel)
   );

   muxn_arb #(.WIDTH(8), .N(4), .RR(0)) u_fp (
      .clk(clk), .reset(rst_n),
      .in_data(fp_in_data), .in_valid(fp_in_valid), .in_ready(fp_in_ready),
      .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(fp_out_ready),
      .out_sel(fp_out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Consumer side: every word accepted downstream must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && rr_out_valid && rr_out_ready) begin
         if (rr_q.size() == 0) begin
            check("rr_sb_underflow", 32'(rr_q.size()), 32'd1);
         end else begin
            rr_exp = rr_q.pop_front();
            check("rr_sb_sel", 32'(rr_out_sel), 32'(rr_exp[15:8]));
            check("rr_sb_data", 32'(rr_out_data), 32'(rr_exp[7:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && fp_out_valid && fp_out_ready) begin
         if (fp_q.size() == 0) begin
            check("fp_sb_underflow", 32'(fp_q.size()), 32'd1);
         end else begin
            fp_exp = fp_q.pop_front();
            check("fp_sb_sel", 32'(fp_out_sel), 32'(fp_exp[15:8]));
            check("fp_sb_data", 32'(fp_out_data), 32'(fp_exp[7:0]));
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      rr_in_data   = 32'h0;
      rr_in_valid  = 4'b0000;
      rr_out_ready = 1'b0;
      fp_in_data   = 32'h0;
      fp_in_valid  = 4'b0000;
      fp_out_ready = 1'b0;

      repeat (2) @(posedge clk);
      smp();
      check("rst_valid", 32'(rr_out_valid), 32'd0);
      check("rst_data", 32'(rr_out_data), 32'd0);
      check("rst_sel", 32'(rr_out_sel), 32'd0);
      cyc();
      rst_n = 1'b1;
      smp();
      check("idle_ready", 32'(rr_in_ready), 32'd0);
      check("idle_valid", 32'(rr_out_valid), 32'd0);

      // round-robin over four always-valid channels
      cyc();
      rr_in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
      rr_in_valid  = 4'b1111;
      rr_out_ready = 1'b1;
      rr_q.push_back({8'd0, 8'h10});
      rr_q.push_back({8'd1, 8'h21});
      rr_q.push_back({8'd2, 8'h32});
      rr_q.push_back({8'd3, 8'h43});
      rr_q.push_back({8'd0, 8'h10});
      rr_q.push_back({8'd1, 8'h21});
      for (int i = 0; i < 6; i++) begin
         smp();
         exp_rdy = 4'b0001 << (i % 4);
         check("rr_grant", 32'(rr_in_ready), 32'(exp_rdy));
         if (i > 0) check("rr_no_bubble", 32'(rr_out_valid), 32'd1);
         cyc();
      end

      // last grant 2, then only channels 3 and 1 requesting
      rr_in_valid = 4'b0100;
      rr_q.push_back({8'd2, 8'h32});
      rr_q.push_back({8'd3, 8'h43});
      rr_q.push_back({8'd1, 8'h21});
      rr_q.push_back({8'd3, 8'h43});
      smp();
      check("wrap_pre", 32'(rr_in_ready), 32'(4'b0100));
      for (int j = 0; j < 3; j++) begin
         cyc();
         rr_in_valid = 4'b1010;
         smp();
         check("wrap_grant", 32'(rr_in_ready), 32'(wrap_rdy[j]));
      end
      cyc();
      rr_in_valid = 4'b0000;
      smp();
      cyc();
      smp();
      check("drain_idle", 32'(rr_out_valid), 32'd0);

      // backpressure: hold 0x55 for three stalled cycles with every channel requesting
      cyc();
      rr_in_data  = {8'h88, 8'h77, 8'h66, 8'h55};
      rr_in_valid = 4'b0001;
      rr_q.push_back({8'd0, 8'h55});
      rr_q.push_back({8'd1, 8'h66});
      smp();
      check("bp_load", 32'(rr_in_ready), 32'(4'b0001));
      cyc();
      rr_out_ready = 1'b0;
      rr_in_valid  = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         smp();
         check("bp_ready", 32'(rr_in_ready), 32'd0);
         check("bp_data", 32'(rr_out_data), 32'h55);
         check("bp_sel", 32'(rr_out_sel), 32'd0);
         check("bp_valid", 32'(rr_out_valid), 32'd1);
         cyc();
      end
      rr_out_ready = 1'b1;
      smp();
      check("bp_resume", 32'(rr_in_ready), 32'(4'b0010));
      cyc();
      rr_in_valid = 4'b0000;
      smp();
      cyc();

      // drain and load in the same cycle
      rr_in_data  = {8'h88, 8'hAA, 8'h66, 8'h0F};
      rr_in_valid = 4'b0100;
      rr_q.push_back({8'd2, 8'hAA});
      rr_q.push_back({8'd0, 8'h0F});
      smp();
      check("dl_first", 32'(rr_in_ready), 32'(4'b0100));
      cyc();
      rr_in_valid = 4'b0001;
      smp();
      check("dl_hold_data", 32'(rr_out_data), 32'hAA);
      check("dl_ready", 32'(rr_in_ready), 32'(4'b0001));
      cyc();
      rr_in_valid = 4'b0000;
      smp();
      check("dl_valid", 32'(rr_out_valid), 32'd1);
      check("dl_data", 32'(rr_out_data), 32'h0F);
      cyc();

      // asynchronous reset in the middle of a stall
      rr_in_data  = {8'hAA, 8'h77, 8'h66, 8'h0F};
      rr_in_valid = 4'b1000;
      smp();
      check("rs_grant", 32'(rr_in_ready), 32'(4'b1000));
      cyc();
      rr_in_valid  = 4'b0000;
      rr_out_ready = 1'b0;
      smp();
      check("rs_pre_valid", 32'(rr_out_valid), 32'd1);
      check("rs_pre_data", 32'(rr_out_data), 32'hAA);
      check("rs_pre_sel", 32'(rr_out_sel), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("rs_valid", 32'(rr_out_valid), 32'd0);
      check("rs_data", 32'(rr_out_data), 32'd0);
      check("rs_sel", 32'(rr_out_sel), 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      smp();
      check("rs_post_valid", 32'(rr_out_valid), 32'd0);
      check("rs_post_ready", 32'(rr_in_ready), 32'd0);
      cyc();
      rr_in_valid  = 4'b1111;
      rr_out_ready = 1'b1;
      rr_q.push_back({8'd0, 8'h0F});
      smp();
      check("rs_ptr", 32'(rr_in_ready), 32'(4'b0001));
      cyc();
      rr_in_valid = 4'b0000;
      smp();
      cyc();

      // fixed priority: channel 1 always beats channel 2
      fp_in_data   = {8'h44, 8'h22, 8'h11, 8'h00};
      fp_in_valid  = 4'b0110;
      fp_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) fp_q.push_back({8'd1, 8'h11});
      fp_q.push_back({8'd2, 8'h22});
      for (int i = 0; i < 4; i++) begin
         smp();
         check("fp_grant", 32'(fp_in_ready), 32'(4'b0010));
         cyc();
      end
      fp_in_valid = 4'b0100;
      smp();
      check("fp_second", 32'(fp_in_ready), 32'(4'b0100));
      cyc();
      fp_in_valid = 4'b0000;
      smp();
      cyc();
      smp();

      check("rr_sb_left", 32'(rr_q.size()), 32'd0);
      check("fp_sb_left", 32'(fp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
